// File: rtl/tpu_test_ctrl.sv
// Test controller for a matrix-multiply unit: streams k stimulus beats into the unit,
// then compares m result beats against a golden memory and reports pass/fail.
module tpu_test_ctrl #(
    parameter int DATA_W  = 256,
    parameter int DIM_W   = 5,
    parameter int ADDR_W  = 10,
    parameter int CNT_W   = 16,
    parameter int MAX_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_m,
    input  logic [DIM_W-1:0]  cfg_n,
    input  logic [DIM_W-1:0]  cfg_k,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic [DATA_W-1:0] gold_data,
    output logic [ADDR_W-1:0] src_addr,
    output logic [ADDR_W-1:0] gold_addr,
    output logic              in_valid,
    output logic [DATA_W-1:0] gbuff_a,
    output logic [DATA_W-1:0] gbuff_b,
    output logic [DIM_W-1:0]  m,
    output logic [DIM_W-1:0]  n,
    output logic [DIM_W-1:0]  k,
    input  logic [DATA_W-1:0] gbuff_out,
    input  logic              out_valid,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic              spurious,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  cyc_cnt
);

    localparam int WAIT_W = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DIM_W-1:0]    m_q, m_d, n_q, n_d, k_q, k_d;
    logic [DIM_W-1:0]    beat_q, beat_d;
    logic [DIM_W-1:0]    rcv_q, rcv_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [ADDR_W-1:0]   src_addr_q, src_addr_d;
    logic [ADDR_W-1:0]   gold_addr_q, gold_addr_d;
    logic                in_valid_q, in_valid_d;
    logic [DATA_W-1:0]   gbuff_a_q, gbuff_a_d, gbuff_b_q, gbuff_b_d;
    logic                pass_q, pass_d;
    logic                timeout_q, timeout_d;
    logic                spurious_q, spurious_d;
    logic [CNT_W-1:0]    err_q, err_d;
    logic [CNT_W-1:0]    cyc_q, cyc_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d     = state_q;
        m_d         = m_q;
        n_d         = n_q;
        k_d         = k_q;
        beat_d      = beat_q;
        rcv_d       = rcv_q;
        wait_d      = wait_q;
        src_addr_d  = src_addr_q;
        gold_addr_d = gold_addr_q;
        in_valid_d  = in_valid_q;
        gbuff_a_d   = gbuff_a_q;
        gbuff_b_d   = gbuff_b_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        spurious_d  = spurious_q;
        err_d       = err_q;
        cyc_d       = cyc_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (out_valid) begin
                    spurious_d = 1'b1;
                end
                if (start) begin
                    m_d         = cfg_m;
                    n_d         = cfg_n;
                    k_d         = cfg_k;
                    src_addr_d  = '0;
                    gold_addr_d = '0;
                    err_d       = '0;
                    cyc_d       = '0;
                    timeout_d   = 1'b0;
                    spurious_d  = 1'b0;
                    pass_d      = 1'b0;
                    beat_d      = '0;
                    rcv_d       = '0;
                    wait_d      = '0;
                    if (cfg_k == '0 || cfg_m == '0) begin
                        state_d = DONE;
                    end else begin
                        // The read index presents word 0 outside a run, so the
                        // accepting edge already captures the first beat.
                        state_d    = LOAD;
                        gbuff_a_d  = src_a;
                        gbuff_b_d  = src_b;
                        in_valid_d = 1'b1;
                        src_addr_d = ADDR_W'(1);
                        beat_d     = DIM_W'(1);
                    end
                end
            end

            LOAD: begin
                cyc_d = sat_inc(cyc_q);
                if (out_valid) begin
                    spurious_d = 1'b1;
                end
                if (beat_q == k_q) begin
                    in_valid_d = 1'b0;
                    state_d    = WAIT;
                end else begin
                    gbuff_a_d  = src_a;
                    gbuff_b_d  = src_b;
                    src_addr_d = src_addr_q + ADDR_W'(1);
                    beat_d     = beat_q + DIM_W'(1);
                end
            end

            WAIT: begin
                cyc_d  = sat_inc(cyc_q);
                wait_d = wait_q + WAIT_W'(1);
                if (out_valid) begin
                    if (gbuff_out != gold_data) begin
                        err_d = sat_inc(err_q);
                    end
                    gold_addr_d = gold_addr_q + ADDR_W'(1);
                    rcv_d       = rcv_q + DIM_W'(1);
                    if (rcv_d == m_q) begin
                        state_d = DONE;
                        pass_d  = (err_d == '0) && !timeout_q && !spurious_q;
                    end
                end
                // The final result beat wins over a timeout landing in the same cycle.
                if (state_d != DONE && wait_q == WAIT_W'(MAX_CYC - 1)) begin
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                    state_d   = DONE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            m_q         <= '0;
            n_q         <= '0;
            k_q         <= '0;
            beat_q      <= '0;
            rcv_q       <= '0;
            wait_q      <= '0;
            src_addr_q  <= '0;
            gold_addr_q <= '0;
            in_valid_q  <= 1'b0;
            gbuff_a_q   <= '0;
            gbuff_b_q   <= '0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            spurious_q  <= 1'b0;
            err_q       <= '0;
            cyc_q       <= '0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            n_q         <= n_d;
            k_q         <= k_d;
            beat_q      <= beat_d;
            rcv_q       <= rcv_d;
            wait_q      <= wait_d;
            src_addr_q  <= src_addr_d;
            gold_addr_q <= gold_addr_d;
            in_valid_q  <= in_valid_d;
            gbuff_a_q   <= gbuff_a_d;
            gbuff_b_q   <= gbuff_b_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            spurious_q  <= spurious_d;
            err_q       <= err_d;
            cyc_q       <= cyc_d;
        end
    end

    assign busy      = (state_q == LOAD) || (state_q == WAIT);
    assign done      = (state_q == DONE);
    assign src_addr  = busy ? src_addr_q : '0;
    assign gold_addr = gold_addr_q;
    assign in_valid  = in_valid_q;
    assign gbuff_a   = gbuff_a_q;
    assign gbuff_b   = gbuff_b_q;
    assign m         = m_q;
    assign n         = n_q;
    assign k         = k_q;
    assign pass      = pass_q;
    assign timeout   = timeout_q;
    assign spurious  = spurious_q;
    assign err_cnt   = err_q;
    assign cyc_cnt   = cyc_q;

endmodule

// File: doc/tpu_test_ctrl.md
TPU_TEST_CTRL -- requirements
Module: tpu_test_ctrl

Interface
REQ-001 Parameter DATA_W, default 256: width of the gbuff_a, gbuff_b and gbuff_out words.
REQ-002 Parameter DIM_W, default 5: width of the m, n and k dimension fields.
REQ-003 Parameter ADDR_W, default 10: width of the stimulus and golden memory addresses.
REQ-004 Parameter CNT_W, default 16: width of the cycle counter and error counter.
REQ-005 Parameter MAX_CYC, default 4096: timeout limit on the wait for outputs, in cycles.
REQ-006 Ports SHALL be as follows; one clock, reset asynchronous active-low:
  clk  in  1  clock
  rst_n  in  1  asynchronous active-low reset
  start  in  1  single-cycle run request
  cfg_m, cfg_n, cfg_k  in  DIM_W  dimensions for the run
  src_a, src_b  in  DATA_W  stimulus words at src_addr (asynchronous-read memory)
  gold_data  in  DATA_W  expected result word at gold_addr (asynchronous-read memory)
  src_addr  out  ADDR_W  stimulus read index
  gold_addr  out  ADDR_W  golden read index
  in_valid  out  1  stimulus beat valid, to the DUT
  gbuff_a, gbuff_b  out  DATA_W  registered stimulus words, to the DUT
  m, n, k  out  DIM_W  latched dimensions, to the DUT
  gbuff_out  in  DATA_W  DUT result word
  out_valid  in  1  DUT result beat valid
  busy  out  1  run in progress
  done  out  1  run finished (level)
  pass  out  1  result of the finished run
  timeout  out  1  sticky timeout flag
  spurious  out  1  sticky flag for an unexpected out_valid
  err_cnt  out  CNT_W  count of mismatched result beats
  cyc_cnt  out  CNT_W  cycles from the first in_valid to done

Function
REQ-007 The state machine SHALL have four states: IDLE, LOAD, WAIT and DONE.
REQ-008 In IDLE or DONE, start=1 SHALL:
  - latch cfg_m, cfg_n and cfg_k into m, n and k;
  - clear src_addr, gold_addr, err_cnt, cyc_cnt, timeout, spurious, done and pass;
  - move to LOAD.
REQ-009 In LOAD or WAIT, start SHALL be ignored.
REQ-010 If cfg_k==0 or cfg_m==0 when start is accepted, the block SHALL go directly to DONE with pass=0 and in_valid never asserted.
REQ-011 LOAD SHALL register src_a/src_b into gbuff_a/gbuff_b with in_valid=1 and then increment src_addr, for exactly k consecutive cycles.
REQ-012 The first in_valid SHALL occur in the cycle after start is sampled.
REQ-013 in_valid SHALL deassert in the cycle after the k-th beat, and the state SHALL then be WAIT.
REQ-014 m, n and k SHALL stay stable from LOAD through DONE.
REQ-015 While in_valid=0, gbuff_a/gbuff_b SHALL hold their last value.
REQ-016 In WAIT, each cycle with out_valid=1 SHALL compare all DATA_W bits of gbuff_out against gold_data; on a mismatch err_cnt SHALL increment (saturating at all-ones); gold_addr SHALL then increment.
REQ-017 After exactly m result beats the block SHALL enter DONE in the next cycle.
REQ-018 On entering DONE, pass SHALL be 1 iff err_cnt==0, timeout==0 and spurious==0.
REQ-019 out_valid=1 in IDLE, LOAD or DONE SHALL set spurious (sticky), with no compare and no change to gold_addr.
REQ-020 A WAIT dwell reaching MAX_CYC cycles without m result beats SHALL set timeout, enter DONE and set pass=0.
REQ-021 cyc_cnt SHALL increment every cycle in LOAD and WAIT, saturating at all-ones, and SHALL freeze in DONE.
REQ-022 busy SHALL be 1 exactly in LOAD and WAIT.
REQ-023 done SHALL be 1 exactly in DONE.
REQ-024 src_addr and gold_addr SHALL wrap modulo 2^ADDR_W.

Reset
REQ-025 While rst_n=0, asynchronously:
  - the state SHALL be IDLE;
  - in_valid, busy, done, pass, timeout and spurious SHALL be 0;
  - all counters, addresses, m, n, k, gbuff_a and gbuff_b SHALL be 0.
REQ-026 rst_n asserted mid-run SHALL abort the run with no done indication.
REQ-027 After rst_n deasserts, the block SHALL wait for a new start.

Verification
REQ-028 Nominal run: m=4, k=3, golden memory matches DUT output, out_valid arriving 10 cycles after the last in_valid -> in_valid high for 3 cycles, then done=1, pass=1, err_cnt=0, cyc_cnt=17.
REQ-029 Mismatch: same run with result beats 1 and 3 corrupted -> err_cnt=2, pass=0.
REQ-030 Timeout: MAX_CYC=16, DUT never asserts out_valid -> timeout=1 and done=1 in the 17th WAIT cycle, pass=0.
REQ-031 Spurious output and restart:
  - out_valid pulse during LOAD -> spurious=1, gold_addr unchanged, pass=0 at the end of the run;
  - start in DONE -> all flags cleared and a new run starts.
REQ-032 Zero dimension and reset abort:
  - cfg_k=0 -> done=1 in the next cycle, in_valid never high, pass=0;
  - rst_n pulsed in WAIT -> IDLE, all outputs 0, and a later start works normally.
